// File: rtl/bus_pkg.sv
// Shared bus definitions for the serial master/slave port pair.
// Holds field widths, the port state encoding and the burst frame layout.
// No logic; imported by master_serial_port, serial_shift_tx users and slave_port.
package bus_pkg;

  localparam int ADDR_W        = 12;
  localparam int DATA_W        = 8;
  localparam int LEN_W         = 12;
  localparam int BURST_FRAME_W = LEN_W + 1;

  // Burst frame layout: bit 0 is the burst enable, bits LEN_W:1 carry the length.
  localparam int BURST_EN_BIT  = 0;
  localparam int BURST_LEN_LSB = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_WAIT,
    ST_HDR_SEND,
    ST_WBEAT,
    ST_RD_WAIT,
    ST_RD_RECV,
    ST_DONE
  } state_e;

endpackage

// File: rtl/serial_shift_tx.sv
// Parallel-load, LSB-first shift register; zeros fill from the top as bits leave.
// Latency: bit_o shows bit 0 the cycle after load_i, next bit the cycle after each shift_i.
// Backpressure: none internally; the caller withholds shift_i to stall the current bit.
// Ports: clk, reset (async, active-high), load_i/load_dat_i, shift_i, bit_o.
module serial_shift_tx #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_dat_i,
  input  logic         shift_i,
  output logic         bit_o
);

  logic [W-1:0] sr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= load_dat_i;
    end else if (shift_i) begin
      sr_q <= sr_q >> 1;
    end
  end

  assign bit_o = sr_q[0];

endmodule

// File: rtl/master_serial_port.sv
// Master bus port: serialises address/data/burst frames to slave_port and deserialises read bytes.
// Latency: master_valid rises 1 cycle after req accept; rd_valid 1 cycle after the 8th return bit.
// Backpressure: slave_ready low holds the current frame bit; slave_valid gaps stall read assembly.
// Ports: req_* parallel request, wr_next/wr_data burst write feed, tx_* serial out with
// master_valid/slave_ready, rx_data in with slave_valid/master_ready, rd_data/rd_valid, busy.
module master_serial_port #(
  parameter int ADDR_W = bus_pkg::ADDR_W,
  parameter int DATA_W = bus_pkg::DATA_W,
  parameter int LEN_W  = bus_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_burst,
  input  logic [LEN_W-1:0]  req_len,
  output logic              wr_next,
  input  logic [DATA_W-1:0] wr_data,
  output logic              read_en,
  output logic              write_en,
  output logic              master_valid,
  output logic              master_ready,
  input  logic              slave_ready,
  input  logic              slave_valid,
  output logic              tx_address,
  output logic              tx_data,
  output logic              tx_burst,
  input  logic              rx_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
);

  import bus_pkg::*;

  localparam int FRAME_W = LEN_W + 1;
  localparam int CNT_W   = $clog2(((FRAME_W > DATA_W) ? FRAME_W : DATA_W) + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [LEN_W-1:0]   beats_left_q, beats_left_d;
  logic               write_q, write_d;
  logic               burst_q, burst_d;
  logic               wload_q, wload_d;      // WBEAT is in its wr_next/load cycle
  logic [DATA_W-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  logic               hdr_load, hdr_shift, dat_load, dat_shift;
  logic [DATA_W-1:0]  dat_load_val;
  logic [DATA_W-1:0]  rx_next;
  logic               addr_bit, data_bit, burst_bit;

  // New bits enter at the MSB so the first (LSB-first) bit ends up in bit 0.
  assign rx_next = {rx_data, rx_shift_q[DATA_W-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      beats_left_q <= '0;
      write_q      <= 1'b0;
      burst_q      <= 1'b0;
      wload_q      <= 1'b0;
      rx_shift_q   <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      beats_left_q <= beats_left_d;
      write_q      <= write_d;
      burst_q      <= burst_d;
      wload_q      <= wload_d;
      rx_shift_q   <= rx_shift_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    beats_left_d = beats_left_q;
    write_d      = write_q;
    burst_d      = burst_q;
    wload_d      = wload_q;
    rx_shift_d   = rx_shift_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    hdr_load     = 1'b0;
    hdr_shift    = 1'b0;
    dat_load     = 1'b0;
    dat_shift    = 1'b0;
    dat_load_val = '0;
    master_valid = 1'b0;
    master_ready = 1'b0;
    wr_next      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d      = req_write;
          burst_d      = req_burst;
          beats_left_d = req_burst ? req_len : '0;
          hdr_load     = 1'b1;
          dat_load     = 1'b1;
          dat_load_val = req_write ? req_wdata : '0;
          k_d          = '0;
          state_d      = ST_HDR_WAIT;
        end
      end
      // Bit 0 is already on the lines; this cycle only waits for the slave.
      ST_HDR_WAIT: begin
        master_valid = 1'b1;
        if (slave_ready) state_d = ST_HDR_SEND;
      end
      ST_HDR_SEND: begin
        master_valid = 1'b1;
        if (slave_ready) begin
          hdr_shift = 1'b1;
          dat_shift = 1'b1;
          if (k_q == CNT_W'(LEN_W)) begin
            k_d = '0;
            if (!write_q) begin
              state_d = ST_RD_WAIT;
            end else if (!burst_q || (beats_left_q == '0)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_WBEAT;
              wload_d = 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_WBEAT: begin
        if (wload_q) begin
          wr_next      = 1'b1;
          dat_load     = 1'b1;
          dat_load_val = wr_data;
          wload_d      = 1'b0;
          k_d          = '0;
        end else begin
          master_valid = 1'b1;
          if (slave_ready) begin
            dat_shift = 1'b1;
            if (k_q == CNT_W'(DATA_W - 1)) begin
              k_d = '0;
              if (beats_left_q != '0) beats_left_d = beats_left_q - 1'b1;
              if (beats_left_q <= LEN_W'(1)) state_d = ST_DONE;
              else                           wload_d = 1'b1;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
      end
      ST_RD_WAIT: begin
        master_ready = 1'b1;
        if (slave_valid) begin
          rx_shift_d = rx_next;
          k_d        = CNT_W'(1);
          state_d    = ST_RD_RECV;
        end
      end
      ST_RD_RECV: begin
        master_ready = 1'b1;
        if (slave_valid) begin
          rx_shift_d = rx_next;
          if (k_q == CNT_W'(DATA_W - 1)) begin
            k_d        = '0;
            rd_data_d  = rx_next;
            rd_valid_d = 1'b1;
            if (burst_q && (beats_left_q != '0)) beats_left_d = beats_left_q - 1'b1;
            else                                 state_d      = ST_DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  serial_shift_tx #(.W(ADDR_W)) u_tx_addr (
    .clk(clk), .reset(reset), .load_i(hdr_load), .load_dat_i(req_addr),
    .shift_i(hdr_shift), .bit_o(addr_bit)
  );

  serial_shift_tx #(.W(DATA_W)) u_tx_data (
    .clk(clk), .reset(reset), .load_i(dat_load), .load_dat_i(dat_load_val),
    .shift_i(dat_shift), .bit_o(data_bit)
  );

  // A non-burst request carries a zero length so the burst line stays quiet.
  serial_shift_tx #(.W(FRAME_W)) u_tx_burst (
    .clk(clk), .reset(reset), .load_i(hdr_load),
    .load_dat_i({(req_burst ? req_len : {LEN_W{1'b0}}), req_burst}),
    .shift_i(hdr_shift), .bit_o(burst_bit)
  );

  assign tx_address = master_valid & addr_bit;
  assign tx_data    = master_valid & data_bit;
  assign tx_burst   = master_valid & burst_bit;

  assign busy      = (state_q != ST_IDLE);
  assign req_ready = (state_q == ST_IDLE) & ~reset;
  assign read_en   = busy & (state_q != ST_DONE) & ~write_q;
  assign write_en  = busy & (state_q != ST_DONE) &  write_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule
